// File: rtl/spi_master_clkgen_burst.sv
// SPI serial-clock generator: emits a burst of n_cycles SPI clock periods with edge/sample/shift strobes.
// Optional feature macro: SPI_CLKGEN_STALL_EN adds a stall input that pauses the clock between periods.
module spi_master_clkgen_burst #(
  parameter int DIV_W = 8,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [CYC_W-1:0] n_cycles,
`ifdef SPI_CLKGEN_STALL_EN
  input  logic             stall,
`endif
  output logic             busy,
  output logic             done,
  output logic             spi_clk,
  output logic             spi_rise,
  output logic             spi_fall,
  output logic             sample,
  output logic             shift
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [CYC_W:0]   edge_reg, edge_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic             cpol_reg, cpol_next;
  logic             cpha_reg, cpha_next;
  logic [CYC_W-1:0] n_reg, n_next;
  logic             clk_reg, clk_next;
  logic             done_reg, done_next;

  logic             stall_req;
  logic             at_div;
  logic             leading;
  logic             last;
  logic             fire;
  logic [CYC_W:0]   last_edge;

`ifdef SPI_CLKGEN_STALL_EN
  assign stall_req = stall;
`else
  assign stall_req = 1'b0;
`endif

  // Edge index of the final trailing edge: 2*n - 1.
  assign last_edge = {n_reg, 1'b0} - (CYC_W+1)'(1);
  assign at_div    = (cnt_reg == div_reg);
  assign leading   = ~edge_reg[0];
  assign last      = (edge_reg == last_edge);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      edge_reg  <= '0;
      div_reg   <= '0;
      cpol_reg  <= 1'b0;
      cpha_reg  <= 1'b0;
      n_reg     <= '0;
      clk_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      edge_reg  <= edge_next;
      div_reg   <= div_next;
      cpol_reg  <= cpol_next;
      cpha_reg  <= cpha_next;
      n_reg     <= n_next;
      clk_reg   <= clk_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    edge_next  = edge_reg;
    div_next   = div_reg;
    cpol_next  = cpol_reg;
    cpha_next  = cpha_reg;
    n_next     = n_reg;
    clk_next   = clk_reg;
    done_next  = 1'b0;
    fire       = 1'b0;

    case (state_reg)
      IDLE: begin
        clk_next = cpol_reg;
        // abort in the same cycle drops the request entirely
        if (start && !abort) begin
          div_next  = clk_div;
          cpol_next = cpol;
          cpha_next = cpha;
          n_next    = n_cycles;
          clk_next  = cpol;
          cnt_next  = '0;
          edge_next = '0;
          if (n_cycles == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          clk_next   = cpol_reg;
          cnt_next   = '0;
        end else if (at_div) begin
          // Between periods the clock may be held; trailing edges always fire.
          if (!(leading && stall_req)) begin
            fire      = 1'b1;
            clk_next  = ~clk_reg;
            cnt_next  = '0;
            edge_next = edge_reg + (CYC_W+1)'(1);
            if (last) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end else begin
          cnt_next = cnt_reg + DIV_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy     = (state_reg == RUN);
  assign done     = done_reg;
  assign spi_clk  = clk_reg;
  assign spi_rise = fire & ~clk_reg;
  assign spi_fall = fire &  clk_reg;
  // cpha=0: bit 0 is preloaded, so the last trailing edge has nothing left to shift.
  assign sample   = fire & (cpha_reg ? ~leading : leading);
  assign shift    = fire & (cpha_reg ? leading : (~leading & ~last));

endmodule

// File: tb/tb_spi_master_clkgen_burst.sv
// Directed bench for spi_master_clkgen_burst: per-cycle output masks compared against hand-derived values.
// Bit k of each mask records the output during cycle T+k, where T is the start cycle.
module tb_spi_master_clkgen_burst;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       abort;
  logic [7:0] clk_div;
  logic       cpol;
  logic       cpha;
  logic [7:0] n_cycles;
  logic       stall;
  logic       busy, done, spi_clk, spi_rise, spi_fall, sample, shift;

  int checks;
  int failures;

  logic [31:0] m_rise, m_fall, m_sample, m_shift, m_done, m_busy, m_clk;

  spi_master_clkgen_burst #(.DIV_W(8), .CYC_W(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .abort    (abort),
    .clk_div  (clk_div),
    .cpol     (cpol),
    .cpha     (cpha),
    .n_cycles (n_cycles),
`ifdef SPI_CLKGEN_STALL_EN
    .stall    (stall),
`endif
    .busy     (busy),
    .done     (done),
    .spi_clk  (spi_clk),
    .spi_rise (spi_rise),
    .spi_fall (spi_fall),
    .sample   (sample),
    .shift    (shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Runs one burst for ncyc cycles, with optional extra stimulus at given cycle indices.
  task automatic run_burst(input logic [7:0] div, input logic pol, input logic pha,
                           input logic [7:0] n, input int ncyc, input int restart_at,
                           input int abort_at, input int chg_at, input logic [7:0] chg_div,
                           input int stall_lo, input int stall_hi, input int stall_extra);
    m_rise = '0; m_fall = '0; m_sample = '0; m_shift = '0;
    m_done = '0; m_busy = '0; m_clk = '0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      start    = (k == 0) || (k == restart_at);
      abort    = (k == abort_at);
      clk_div  = (k == chg_at) ? chg_div : div;
      cpol     = pol;
      cpha     = pha;
      n_cycles = n;
      stall    = ((k >= stall_lo) && (k <= stall_hi)) || (k == stall_extra);
      #1;
      m_rise[k]   = spi_rise;
      m_fall[k]   = spi_fall;
      m_sample[k] = sample;
      m_shift[k]  = shift;
      m_done[k]   = done;
      m_busy[k]   = busy;
      m_clk[k]    = spi_clk;
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; stall = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; clk_div = '0;
    cpol = 1'b0; cpha = 1'b0; n_cycles = '0; stall = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_outputs", {25'd0, busy, done, spi_clk, spi_rise, spi_fall, sample, shift}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: div=0 mode 0, two periods
    run_burst(8'd0, 1'b0, 1'b0, 8'd2, 8, -1, -1, -1, 8'd0, -1, -1, -1);
    check_eq("t1_rise",   m_rise,   32'h0000000A);
    check_eq("t1_fall",   m_fall,   32'h00000014);
    check_eq("t1_sample", m_sample, 32'h0000000A);
    check_eq("t1_shift",  m_shift,  32'h00000004);
    check_eq("t1_done",   m_done,   32'h00000020);
    check_eq("t1_busy",   m_busy,   32'h0000001E);
    check_eq("t1_clk",    m_clk,    32'h00000014);

    // 2: div=3, cpol=1, cpha=1, one period
    run_burst(8'd3, 1'b1, 1'b1, 8'd1, 12, -1, -1, -1, 8'd0, -1, -1, -1);
    check_eq("t2_fall",   m_fall,   32'h00000010);
    check_eq("t2_shift",  m_shift,  32'h00000010);
    check_eq("t2_rise",   m_rise,   32'h00000100);
    check_eq("t2_sample", m_sample, 32'h00000100);
    check_eq("t2_done",   m_done,   32'h00000200);
    check_eq("t2_busy",   m_busy,   32'h000001FE);
    check_eq("t2_clk",    m_clk,    32'h00000E1E);

    // 3: n=0 gives immediate done, no activity
    run_burst(8'd2, 1'b1, 1'b0, 8'd0, 4, -1, -1, -1, 8'd0, -1, -1, -1);
    check_eq("t3_done",    m_done, 32'h00000002);
    check_eq("t3_busy",    m_busy, 32'h0);
    check_eq("t3_strobes", m_rise | m_fall | m_sample | m_shift, 32'h0);
    check_eq("t3_clk",     m_clk,  32'h0000000F);

    // 4: mid-burst start and clk_div change are ignored
    run_burst(8'd2, 1'b0, 1'b0, 8'd4, 28, 3, -1, 3, 8'd7, -1, -1, -1);
    check_eq("t4_rise",   m_rise,   32'h00208208);
    check_eq("t4_fall",   m_fall,   32'h01041040);
    check_eq("t4_sample", m_sample, 32'h00208208);
    check_eq("t4_shift",  m_shift,  32'h00041040);
    check_eq("t4_done",   m_done,   32'h02000000);
    check_eq("t4_busy",   m_busy,   32'h01FFFFFE);

    // 5: abort in the third edge cycle
    run_burst(8'd1, 1'b0, 1'b0, 8'd4, 10, -1, 6, -1, 8'd0, -1, -1, -1);
    check_eq("t5_rise",   m_rise,   32'h00000004);
    check_eq("t5_fall",   m_fall,   32'h00000010);
    check_eq("t5_shift",  m_shift,  32'h00000010);
    check_eq("t5_done",   m_done,   32'h0);
    check_eq("t5_busy",   m_busy,   32'h0000007E);
    check_eq("t5_clk",    m_clk,    32'h00000018);

    // 7: abort together with start in IDLE drops the start
    run_burst(8'd0, 1'b0, 1'b0, 8'd2, 6, -1, 0, -1, 8'd0, -1, -1, -1);
    check_eq("t7_busy", m_busy, 32'h0);
    check_eq("t7_done", m_done, 32'h0);

    // 8: back-to-back start in the done cycle
    run_burst(8'd0, 1'b0, 1'b0, 8'd1, 9, 3, -1, -1, 8'd0, -1, -1, -1);
    check_eq("t8_rise", m_rise, 32'h00000012);
    check_eq("t8_fall", m_fall, 32'h00000024);
    check_eq("t8_done", m_done, 32'h00000048);
    check_eq("t8_busy", m_busy, 32'h00000036);

`ifdef SPI_CLKGEN_STALL_EN
    // 6: stall before the first leading edge; stall at a trailing edge has no effect
    run_burst(8'd1, 1'b0, 1'b0, 8'd2, 16, -1, -1, -1, 8'd0, 2, 6, 9);
    check_eq("t6_rise", m_rise, 32'h00000880);
    check_eq("t6_fall", m_fall, 32'h00002200);
    check_eq("t6_done", m_done, 32'h00004000);
    check_eq("t6_busy", m_busy, 32'h00003FFE);
`endif

    // Asynchronous reset mid-burst, away from any clock edge
    @(negedge clk);
    clk_div = 8'd0; cpol = 1'b1; cpha = 1'b0; n_cycles = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("ar_busy_before", {31'd0, busy}, 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("ar_outputs", {25'd0, busy, done, spi_clk, spi_rise, spi_fall, sample, shift}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
